traffic_phase_scheduler: RTL and testbench
==========================================

# traffic_phase_scheduler

Phase scheduler for a highway/country-road intersection with a pedestrian crossing and emergency preemption. It owns the signal-head sequence for both roads. It arbitrates among three requesters: the country-road car sensor, a latched pedestrian button and an emergency preempt. It times every phase from a shared 1 Hz tick strobe and drives the highway/country light codes and the walk lamp directly.

## Interface
- `TW`, 5: width of the phase timer; every duration must be in 1..2^TW-1.
- `MIN_HWY_GREEN`, 10: minimum highway green, in ticks.
- `MAX_CNTRY_GREEN`, 8: maximum country green, in ticks.
- `YELLOW_TIME`, 3: yellow duration, in ticks.
- `ALLRED_TIME`, 2: all-red clearance, in ticks.
- `PED_TIME`, 6: walk duration, in ticks.
- `clk` in 1: single clock; all state changes on the rising edge.
- `clear_n` in 1: asynchronous, active-low reset.
- `tick` in 1: one-cycle timing strobe (1 Hz nominal); synchronous to `clk`.
- `x` in 1: country-road car present (level, not latched).
- `ped_req` in 1: pedestrian button; latched internally.
- `emerg_req` in 1: emergency preempt (level).
- `hwy` out 2: highway light, RED=2'd0, YELLOW=2'd1, GREEN=2'd2.
- `cntry` out 2: country light, same encoding.
- `walk` out 1: pedestrian walk lamp.
- `phase` out 3: current state code, for debug and status.

## Operation
- States and codes, with lights shown as hwy/cntry:
  - HG=0: GREEN/RED
  - HY=1: YELLOW/RED
  - AR=2: RED/RED
  - CG=3: RED/GREEN
  - CY=4: RED/YELLOW
  - PED=5: RED/RED, walk=1
  - EMR=6: RED/RED
- Code 7 is illegal and returns to HG on the next edge.
- Outputs are a pure decode of the state register; no combinational path from inputs.
- Timer:
  - Loaded with the state's duration on every state entry: HG→MIN_HWY_GREEN, HY/CY→YELLOW_TIME, AR→ALLRED_TIME, CG→MAX_CNTRY_GREEN, PED→PED_TIME. EMR loads 0.
  - Decrements on `tick` while nonzero and saturates at 0.
  - `expire` = tick && timer==1.
  - `elapsed` = expire || timer==0.
- `ped_pend`:
  - Set when `ped_req` is sampled high in any state except PED.
  - Cleared on the edge entering PED; a `ped_req` sampled on that edge is dropped.
- `from_hwy`: set on the HY→AR edge, cleared on the CY→AR edge.
- Transitions are evaluated each cycle; the first matching rule wins:
  - HG: `emerg_req` → HY, ignoring min green. Otherwise elapsed && (ped_pend || x) → HY. Otherwise stay; highway green holds indefinitely with no request.
  - HY: elapsed → AR.
  - AR, on elapsed: `emerg_req` → EMR; else ped_pend → PED; else from_hwy && x → CG; else → HG.
  - CG: `emerg_req` → CY; else !x → CY; else elapsed → CY.
  - CY: elapsed → AR.
  - PED: `emerg_req` → EMR. Otherwise elapsed → HG.
  - EMR: stays while `emerg_req` is high. On release → AR, with from_hwy forced to 0.
- Emergency never skips yellow or all-red from a green phase. It preempts PED immediately; the walk lamp drops on the next edge.

## Timing
- Reset values while `clear_n` is low:
  - state HG, timer MIN_HWY_GREEN, ped_pend 0, from_hwy 0.
  - hwy=GREEN, cntry=RED, walk=0, phase=0.
- Release of `clear_n` is synchronised by the integrator; the first active edge behaves as a normal HG cycle.
- A state with duration D is exited on the clock edge that samples the D-th `tick` after entry. A `tick` sampled on the entry edge itself does not count.
- HG with a request already present exits on the MIN_HWY_GREEN-th tick edge. A request arriving later exits on the first edge that samples it.
- Reaction latencies:
  - `x` deasserting in CG: CY on the next edge.
  - `emerg_req` in HG or CG: yellow on the next edge.
  - Light outputs change on the same edge as `phase`.
- Simultaneous events: `tick`, `x`, `ped_req` and `emerg_req` in one cycle are resolved by the rule order above.
- Reset asserted mid-phase returns all outputs to their reset values immediately (asynchronous). Pending requests are lost.

## Test plan
- **Reset:** assert clear_n=0 mid-CG → hwy=2, cntry=0, walk=0, phase=0 without a clock edge. Release and hold x=0 for 50 ticks → stays HG.
- **Country cycle:** defaults, x=1 from reset → HY after tick 10, AR after tick 13, CG after tick 15. Holding x=1 gives CY after tick 23, AR after 26, HG after 28.
- **Country early release:** in CG drop x after 2 ticks → CY next edge; then AR, then HG (from_hwy=0, no re-serve of country).
- **Pedestrian:** pulse ped_req for one cycle at tick 3 → HY at tick 10, AR, then PED with walk=1 for 6 ticks → HG. A ped_req during PED is ignored and does not repeat PED.
- **Emergency preemption:** emerg_req=1 at tick 4 of HG → HY next edge, AR after 3 ticks, then EMR held RED/RED. Drop emerg_req → AR for 2 ticks → HG.
- **Priority collision:** with ped_pend=1 and x=1 in AR, set emerg_req on the expiring tick edge → EMR. After release, with ped_pend still 1 → AR then PED.

Source files
------------

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: highway/country intersection phase FSM with pedestrian walk and emergency preemption.
module traffic_phase_scheduler #(
    parameter int TW              = 5,
    parameter int MIN_HWY_GREEN   = 10,
    parameter int MAX_CNTRY_GREEN = 8,
    parameter int YELLOW_TIME     = 3,
    parameter int ALLRED_TIME     = 2,
    parameter int PED_TIME        = 6
) (
    input  logic       clk,
    input  logic       clear_n,
    input  logic       tick,
    input  logic       x,
    input  logic       ped_req,
    input  logic       emerg_req,
    output logic [1:0] hwy,
    output logic [1:0] cntry,
    output logic       walk,
    output logic [2:0] phase
);
    localparam logic [1:0] RED = 2'd0, YELLOW = 2'd1, GREEN = 2'd2;
    typedef enum logic [2:0] {
        HG  = 3'd0,
        HY  = 3'd1,
        AR  = 3'd2,
        CG  = 3'd3,
        CY  = 3'd4,
        PED = 3'd5,
        EMR = 3'd6
    } state_t;
    state_t state_q, state_d;
    logic [TW-1:0] timer_q, timer_d, dur;
    logic ped_pend_q, ped_pend_d, from_hwy_q, from_hwy_d;
    logic expire, elapsed, entry;
    assign expire  = tick && timer_q == TW'(1);
    assign elapsed = expire || timer_q == '0;
    always_comb begin
        state_d = state_q;
        case (state_q)
            HG:      if (emerg_req || (elapsed && (ped_pend_q || x))) state_d = HY;
            HY:      if (elapsed) state_d = AR;
            AR:      if (elapsed) state_d = emerg_req ? EMR : ped_pend_q ? PED : (from_hwy_q && x) ? CG : HG;
            CG:      if (emerg_req || !x || elapsed) state_d = CY;
            CY:      if (elapsed) state_d = AR;
            PED:     if (emerg_req) state_d = EMR; else if (elapsed) state_d = HG;
            EMR:     if (!emerg_req) state_d = AR;
            default: state_d = HG;
        endcase
    end
    // Every state entry reloads the timer, so a tick sampled on the entry edge is discarded.
    assign entry = state_d != state_q;
    assign dur = state_d == HG ? TW'(MIN_HWY_GREEN) :
                 (state_d == HY || state_d == CY) ? TW'(YELLOW_TIME) :
                 state_d == AR ? TW'(ALLRED_TIME) :
                 state_d == CG ? TW'(MAX_CNTRY_GREEN) :
                 state_d == PED ? TW'(PED_TIME) : '0;
    always_comb begin
        timer_d    = entry ? dur : (tick && timer_q != '0) ? timer_q - TW'(1) : timer_q;
        ped_pend_d = state_q == PED ? ped_pend_q : state_d == PED ? 1'b0 : ped_pend_q | ped_req;
        from_hwy_d = (entry && state_d == AR) ? state_q == HY : from_hwy_q;
    end
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q    <= HG;
            timer_q    <= TW'(MIN_HWY_GREEN);
            ped_pend_q <= 1'b0;
            from_hwy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            ped_pend_q <= ped_pend_d;
            from_hwy_q <= from_hwy_d;
        end
    end
    assign hwy   = state_q == HG ? GREEN : state_q == HY ? YELLOW : RED;
    assign cntry = state_q == CG ? GREEN : state_q == CY ? YELLOW : RED;
    assign walk  = state_q == PED;
    assign phase = state_q;
endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb_traffic_phase_scheduler: directed checks of phase sequencing, timing and preemption.
module tb_traffic_phase_scheduler;
    logic clk = 1'b0, clear_n = 1'b0, tick = 1'b0, x = 1'b0, ped_req = 1'b0, emerg_req = 1'b0;
    logic [1:0] hwy, cntry;
    logic walk;
    logic [2:0] phase;
    int n_checks = 0, n_errors = 0;

    traffic_phase_scheduler dut (
        .clk(clk), .clear_n(clear_n), .tick(tick), .x(x), .ped_req(ped_req),
        .emerg_req(emerg_req), .hwy(hwy), .cntry(cntry), .walk(walk), .phase(phase)
    );

    always #5 clk = ~clk;

    // Expected {phase, hwy, cntry, walk} for each state code.
    function automatic logic [7:0] st(input int ph);
        case (ph)
            0:       return {3'd0, 2'd2, 2'd0, 1'b0};
            1:       return {3'd1, 2'd1, 2'd0, 1'b0};
            2:       return {3'd2, 2'd0, 2'd0, 1'b0};
            3:       return {3'd3, 2'd0, 2'd2, 1'b0};
            4:       return {3'd4, 2'd0, 2'd1, 1'b0};
            5:       return {3'd5, 2'd0, 2'd0, 1'b1};
            default: return {3'd6, 2'd0, 2'd0, 1'b0};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got {phase,hwy,cntry,walk}=%h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_st(input string tag, input int ph);
        chk(tag, {phase, hwy, cntry, walk}, st(ph));
    endtask

    task automatic cyc(input logic t);
        @(negedge clk);
        tick = t;
        @(posedge clk);
        #1 tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) cyc(1'b1);
    endtask

    task automatic do_reset;
        @(negedge clk);
        clear_n = 1'b0; x = 1'b0; ped_req = 1'b0; emerg_req = 1'b0; tick = 1'b0;
        @(posedge clk);
        #1 clear_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset;
        chk_st("reset_state", 0);
        x = 1'b1;
        ticks(9);  chk_st("hg_t9", 0);
        ticks(1);  chk_st("hy_t10", 1);
        ticks(2);  chk_st("hy_t12", 1);
        ticks(1);  chk_st("ar_t13", 2);
        ticks(1);  chk_st("ar_t14", 2);
        ticks(1);  chk_st("cg_t15", 3);
        ticks(7);  chk_st("cg_t22", 3);
        ticks(1);  chk_st("cy_t23", 4);
        ticks(2);  chk_st("cy_t25", 4);
        ticks(1);  chk_st("ar_t26", 2);
        ticks(1);  chk_st("ar_t27", 2);
        ticks(1);  chk_st("hg_t28", 0);

        ticks(15); chk_st("cg_again", 3);
        ticks(2);  chk_st("cg_2ticks", 3);
        x = 1'b0;
        cyc(1'b0); chk_st("cy_xdrop", 4);
        x = 1'b1;
        ticks(3);  chk_st("ar_after_cy", 2);
        ticks(2);  chk_st("hg_no_reserve", 0);
        ticks(15); chk_st("cg_third", 3);
        @(negedge clk);
        clear_n = 1'b0;
        #1 chk_st("reset_async", 0);
        x = 1'b0;
        @(posedge clk);
        #1 clear_n = 1'b1;
        ticks(50); chk_st("hg_hold_50", 0);

        do_reset;
        ticks(2);
        ped_req = 1'b1; cyc(1'b1); ped_req = 1'b0;
        ticks(6);  chk_st("ped_hg_t9", 0);
        ticks(1);  chk_st("ped_hy_t10", 1);
        ticks(3);  chk_st("ped_ar", 2);
        ticks(2);  chk_st("ped_walk", 5);
        ped_req = 1'b1; cyc(1'b0); ped_req = 1'b0;
        ticks(4);  chk_st("ped_walk_t4", 5);
        ticks(1);  chk_st("ped_walk_t5", 5);
        ticks(1);  chk_st("ped_done", 0);
        ticks(12); chk_st("ped_no_repeat", 0);

        do_reset;
        ticks(4);
        emerg_req = 1'b1;
        cyc(1'b0); chk_st("emr_hy", 1);
        ticks(2);  chk_st("emr_hy_t2", 1);
        ticks(1);  chk_st("emr_ar", 2);
        ticks(1);  chk_st("emr_ar_t1", 2);
        ticks(1);  chk_st("emr_enter", 6);
        ticks(5);  chk_st("emr_hold", 6);
        x = 1'b1; emerg_req = 1'b0;
        cyc(1'b0); chk_st("emr_release_ar", 2);
        ticks(1);  chk_st("emr_ar_t1b", 2);
        ticks(1);  chk_st("emr_to_hg", 0);

        do_reset;
        x = 1'b1;
        ped_req = 1'b1; cyc(1'b0); ped_req = 1'b0;
        ticks(10); chk_st("pri_hy", 1);
        ticks(3);  chk_st("pri_ar", 2);
        ticks(1);
        emerg_req = 1'b1;
        cyc(1'b1); chk_st("pri_emr", 6);
        ticks(3);  chk_st("pri_emr_hold", 6);
        emerg_req = 1'b0;
        cyc(1'b0); chk_st("pri_ar2", 2);
        ticks(2);  chk_st("pri_ped", 5);
        emerg_req = 1'b1;
        cyc(1'b0); chk_st("pri_ped_preempt", 6);
        emerg_req = 1'b0;
        cyc(1'b0); chk_st("pri_ar3", 2);
        ticks(2);  chk_st("pri_hg", 0);

        ticks(15); chk_st("cg_emr_pre", 3);
        emerg_req = 1'b1;
        cyc(1'b0); chk_st("cg_emr_cy", 4);
        ticks(3);  chk_st("cg_emr_ar", 2);
        ticks(2);  chk_st("cg_emr_emr", 6);
        emerg_req = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
